// File: rtl/address_bus_ws_m.sv
//==============================================================================
// Module   : address_bus_ws_m
// Purpose  : Registered 65C02 address decoder with per-region wait states.
//            Matches cpu_address against N_REGIONS base/mask pairs.
//            The lowest matching index wins.
//            Drives a one-hot select and stretches slow accesses by holding
//            cpu_rdy low.
//            The first unmapped access is captured in a sticky error register.
// Ports    : clk              - system clock
//            rst              - asynchronous active-high reset
//            cpu_address      - CPU address
//            cpu_valid        - address valid this cycle
//            select           - one-hot region select
//            cpu_rdy          - CPU ready (low stalls the CPU)
//            unmapped         - sticky unmapped-access flag
//            unmapped_address - address of the first unmapped access
//            clr_unmapped     - one-cycle pulse clearing the unmapped flag
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module address_bus_ws_m #(
    parameter int ADDR_W    = 16,
    parameter int N_REGIONS = 4,
    parameter int WAIT_W    = 4,
    parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE =
        {16'h8000, 16'h4000, 16'h0000, 16'h7000},
    parameter logic [N_REGIONS*ADDR_W-1:0] REGION_MASK =
        {16'h8000, 16'hE000, 16'hC000, 16'hFFFC},
    parameter logic [N_REGIONS*WAIT_W-1:0] REGION_WAIT =
        {4'd3, 4'd2, 4'd0, 4'd1}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    cpu_address,
    input  logic                 cpu_valid,
    output logic [N_REGIONS-1:0] select,
    output logic                 cpu_rdy,
    output logic                 unmapped,
    output logic [ADDR_W-1:0]    unmapped_address,
    input  logic                 clr_unmapped
);

    localparam int IDX_W = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]    reg_q, reg_d;
    logic                unmapped_q, unmapped_d;
    logic [ADDR_W-1:0]   unmapped_addr_q, unmapped_addr_d;

    logic                hit;
    logic [IDX_W-1:0]    hit_idx;
    logic [WAIT_W-1:0]   hit_wait;
    logic                sel_en;
    logic [IDX_W-1:0]    sel_idx;
    logic                rdy;
    logic [N_REGIONS-1:0] sel_onehot;

    // Priority match: scan from the highest index down so that the lowest
    // matching region is the last assignment and therefore wins.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_wait = '0;
        for (int i = N_REGIONS - 1; i >= 0; i--) begin
            if ((cpu_address & REGION_MASK[i*ADDR_W +: ADDR_W]) ==
                REGION_BASE[i*ADDR_W +: ADDR_W]) begin
                hit      = 1'b1;
                hit_idx  = IDX_W'(i);
                hit_wait = REGION_WAIT[i*WAIT_W +: WAIT_W];
            end
        end
    end

    // Next-state and first-cycle outputs. The first cycle of an access is
    // decoded directly from the bus; stalled cycles replay the latched region
    // and ignore the (held) address.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        reg_d           = reg_q;
        unmapped_d      = unmapped_q;
        unmapped_addr_d = unmapped_addr_q;
        sel_en          = 1'b0;
        sel_idx         = reg_q;
        rdy             = 1'b1;

        if (clr_unmapped) begin
            unmapped_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (cpu_valid) begin
                    if (hit) begin
                        sel_en  = 1'b1;
                        sel_idx = hit_idx;
                        if (hit_wait != '0) begin
                            rdy     = 1'b0;
                            state_d = S_WAIT;
                            cnt_d   = hit_wait - WAIT_W'(1);
                            reg_d   = hit_idx;
                        end
                    end else if (!unmapped_q || clr_unmapped) begin
                        // A new unmapped access beats a coincident clear and
                        // becomes the captured address.
                        unmapped_d      = 1'b1;
                        unmapped_addr_d = cpu_address;
                    end
                end
            end
            S_WAIT: begin
                sel_en  = 1'b1;
                sel_idx = reg_q;
                if (cnt_q != '0) begin
                    rdy   = 1'b0;
                    cnt_d = cnt_q - WAIT_W'(1);
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        sel_onehot = '0;
        for (int i = 0; i < N_REGIONS; i++) begin
            sel_onehot[i] = (sel_idx == IDX_W'(i));
        end
    end

    // Reset gates the combinational outputs so an aborted stall releases the
    // CPU in the same cycle rather than at the next edge.
    assign select           = (sel_en && !rst) ? sel_onehot : '0;
    assign cpu_rdy          = rdy | rst;
    assign unmapped         = unmapped_q;
    assign unmapped_address = unmapped_addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            reg_q           <= '0;
            unmapped_q      <= 1'b0;
            unmapped_addr_q <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            reg_q           <= reg_d;
            unmapped_q      <= unmapped_d;
            unmapped_addr_q <= unmapped_addr_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_address_bus_ws_m.sv
//==============================================================================
// Module   : tb_address_bus_ws_m
// Purpose  : Self-checking bench for address_bus_ws_m.
//            DUT A uses the default 4-region map.
//            DUT B uses a 2-region map with 2-bit wait counts.
//            Both are driven with the same stimulus and compared against an
//            access-level reference model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_address_bus_ws_m;

    logic        clk;
    logic        rst;
    logic [15:0] cpu_address;
    logic        cpu_valid;
    logic        clr_unmapped;

    logic [3:0]  sel_a;
    logic        rdy_a;
    logic        unm_a;
    logic [15:0] uaddr_a;
    logic [1:0]  sel_b;
    logic        rdy_b;
    logic        unm_b;
    logic [15:0] uaddr_b;

    int n_checks;
    int n_pass;

    address_bus_ws_m u_dut_a (
        .clk              (clk),
        .rst              (rst),
        .cpu_address      (cpu_address),
        .cpu_valid        (cpu_valid),
        .select           (sel_a),
        .cpu_rdy          (rdy_a),
        .unmapped         (unm_a),
        .unmapped_address (uaddr_a),
        .clr_unmapped     (clr_unmapped)
    );

    // Region 0 = 0x8000/0x8000 with 3 waits (the maximum for 2 bits),
    // region 1 = 0x0000/0xC000 with no waits.
    address_bus_ws_m #(
        .ADDR_W      (16),
        .N_REGIONS   (2),
        .WAIT_W      (2),
        .REGION_BASE ({16'h0000, 16'h8000}),
        .REGION_MASK ({16'hC000, 16'h8000}),
        .REGION_WAIT ({2'd0, 2'd3})
    ) u_dut_b (
        .clk              (clk),
        .rst              (rst),
        .cpu_address      (cpu_address),
        .cpu_valid        (cpu_valid),
        .select           (sel_b),
        .cpu_rdy          (rdy_b),
        .unmapped         (unm_b),
        .unmapped_address (uaddr_b),
        .clr_unmapped     (clr_unmapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Region tables written in natural order (index = region number).
    logic [15:0] m_base [2][4];
    logic [15:0] m_mask [2][4];
    int          m_wait [2][4];
    int          m_nreg [2];

    int          m_rem   [2];   // cycles still owed to the current access
    logic [31:0] m_lsel  [2];   // select of the access in progress
    logic        m_unm   [2];
    logic [15:0] m_uaddr [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_rem[d]   = 0;
            m_lsel[d]  = 0;
            m_unm[d]   = 1'b0;
            m_uaddr[d] = 16'h0000;
        end
    endfunction

    // One bus cycle: drive, compute expectations, check mid-cycle, advance model.
    task automatic step(input logic v, input logic [15:0] a, input logic c);
        logic [31:0] es [2];
        logic        er [2];
        logic        eu [2];
        logic [15:0] eua[2];
        int          r;
        int          w;
        cpu_valid    = v;
        cpu_address  = a;
        clr_unmapped = c;
        for (int d = 0; d < 2; d++) begin
            eu[d]  = m_unm[d];
            eua[d] = m_uaddr[d];
            if (m_rem[d] > 0) begin
                es[d] = m_lsel[d];
                er[d] = (m_rem[d] == 1);
                m_rem[d]--;
                if (c) m_unm[d] = 1'b0;
            end else begin
                es[d] = 0;
                er[d] = 1'b1;
                r = -1;
                w = 0;
                if (v) begin
                    for (int i = 0; i < m_nreg[d]; i++) begin
                        if (r < 0 && (a & m_mask[d][i]) == m_base[d][i]) begin
                            r = i;
                            w = m_wait[d][i];
                        end
                    end
                end
                if (v && r >= 0) begin
                    es[d]     = 32'd1 << r;
                    er[d]     = (w == 0);
                    m_rem[d]  = w;
                    m_lsel[d] = es[d];
                end
                if (v && r < 0 && (!m_unm[d] || c)) begin
                    m_unm[d]   = 1'b1;
                    m_uaddr[d] = a;
                end else if (c) begin
                    m_unm[d] = 1'b0;
                end
            end
        end
        @(negedge clk);
        check("selA",   {28'd0, sel_a},   es[0]);
        check("rdyA",   {31'd0, rdy_a},   {31'd0, er[0]});
        check("unmA",   {31'd0, unm_a},   {31'd0, eu[0]});
        check("uaddrA", {16'd0, uaddr_a}, {16'd0, eua[0]});
        check("selB",   {30'd0, sel_b},   es[1]);
        check("rdyB",   {31'd0, rdy_b},   {31'd0, er[1]});
        check("unmB",   {31'd0, unm_b},   {31'd0, eu[1]});
        check("uaddrB", {16'd0, uaddr_b}, {16'd0, eua[1]});
        @(posedge clk);
        #1;
    endtask

    logic [15:0] hot [11];

    initial begin
        n_checks = 0;
        n_pass   = 0;
        m_nreg[0] = 4;
        m_base[0][0] = 16'h7000; m_mask[0][0] = 16'hFFFC; m_wait[0][0] = 1;
        m_base[0][1] = 16'h0000; m_mask[0][1] = 16'hC000; m_wait[0][1] = 0;
        m_base[0][2] = 16'h4000; m_mask[0][2] = 16'hE000; m_wait[0][2] = 2;
        m_base[0][3] = 16'h8000; m_mask[0][3] = 16'h8000; m_wait[0][3] = 3;
        m_nreg[1] = 2;
        m_base[1][0] = 16'h8000; m_mask[1][0] = 16'h8000; m_wait[1][0] = 3;
        m_base[1][1] = 16'h0000; m_mask[1][1] = 16'hC000; m_wait[1][1] = 0;
        m_base[1][2] = 16'h0000; m_mask[1][2] = 16'h0000; m_wait[1][2] = 0;
        m_base[1][3] = 16'h0000; m_mask[1][3] = 16'h0000; m_wait[1][3] = 0;
        hot = '{16'h0000, 16'h3FFF, 16'hFFFA, 16'h7000, 16'h7003, 16'h7004,
                16'h4000, 16'h5FFF, 16'h6000, 16'h7FFF, 16'h8000};
        model_reset();

        // Reset held with a valid, mapped address on the bus: outputs idle.
        rst          = 1'b1;
        cpu_valid    = 1'b1;
        cpu_address  = 16'h0000;
        clr_unmapped = 1'b0;
        #12;
        check("rst_selA", {28'd0, sel_a}, 32'd0);
        check("rst_rdyA", {31'd0, rdy_a}, 32'd1);
        check("rst_selB", {30'd0, sel_b}, 32'd0);
        check("rst_rdyB", {31'd0, rdy_b}, 32'd1);
        check("rst_unmA", {31'd0, unm_a}, 32'd0);
        check("rst_uaddrA", {16'd0, uaddr_a}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // RAM single-cycle accesses, then ROM with address wiggled while stalled.
        step(1'b1, 16'h0000, 1'b0);
        step(1'b1, 16'h3FFF, 1'b0);
        step(1'b1, 16'hFFFA, 1'b0);
        step(1'b1, 16'h0000, 1'b0);
        step(1'b1, 16'h6000, 1'b0);
        step(1'b1, 16'h4000, 1'b0);
        step(1'b0, 16'h0000, 1'b0);
        // Priority: IO window inside VRAM space, then VRAM edges.
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 16'h7000 + 16'(k), 1'b0);
            step(1'b1, 16'h7000 + 16'(k), 1'b0);
        end
        for (int k = 0; k < 3; k++) step(1'b1, 16'h4000, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, 16'h5FFF, 1'b0);
        // Unmapped capture, stickiness, clear-vs-set.
        step(1'b1, 16'h6000, 1'b0);
        step(1'b1, 16'h7004, 1'b0);
        step(1'b0, 16'h0000, 1'b0);
        step(1'b1, 16'h7FFF, 1'b1);
        step(1'b0, 16'h0000, 1'b0);
        step(1'b0, 16'h0000, 1'b1);
        step(1'b0, 16'h0000, 1'b0);
        // Back-to-back: VRAM then RAM with no bubble.
        step(1'b1, 16'h4000, 1'b0);
        step(1'b1, 16'h4000, 1'b0);
        step(1'b1, 16'h4000, 1'b0);
        step(1'b1, 16'h0000, 1'b0);
        // Idle traffic only.
        for (int k = 0; k < 4; k++) step(1'b0, 16'(k * 16'h3001), 1'b0);

        // Asynchronous reset in the middle of a ROM stall.
        step(1'b1, 16'h8000, 1'b0);
        step(1'b1, 16'h8000, 1'b0);
        rst = 1'b1;
        #1;
        check("abort_selA", {28'd0, sel_a}, 32'd0);
        check("abort_rdyA", {31'd0, rdy_a}, 32'd1);
        check("abort_selB", {30'd0, sel_b}, 32'd0);
        check("abort_rdyB", {31'd0, rdy_b}, 32'd1);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, 16'h0000, 1'b0);

        // Randomised traffic.
        for (int k = 0; k < 600; k++) begin
            logic        v;
            logic        c;
            logic [15:0] a;
            v = ($urandom_range(0, 9) < 8);
            c = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 1) == 0) a = hot[$urandom_range(0, 10)];
            else a = 16'($urandom);
            step(v, a, c);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/address_bus_ws_m.md
# address_bus_ws_m

Parametrised, registered successor to the combinational CPU address decoder. Matches the 65C02 address against N base/mask regions with fixed priority and drives a one-hot select. Stretches accesses to slow regions by pulling `cpu_rdy` low for a per-region number of wait states. Captures the first unmapped access in a sticky error register for firmware/debug readout. Sits between the CPU bus and all memory/IO select consumers.

## Interface
Parameters:
- `ADDR_W`, 16, address width.
- `N_REGIONS`, 4, number of decoded regions (1..16).
- `WAIT_W`, 4, width of each wait-state count.
- `REGION_BASE`, {16'h8000,16'h4000,16'h0000,16'h7000}, packed; region i at `[i*ADDR_W +: ADDR_W]`. Region order is 0=IO, 1=RAM, 2=VRAM, 3=ROM.
- `REGION_MASK`, {16'h8000,16'hE000,16'hC000,16'hFFFC}, packed, same layout.
- `REGION_WAIT`, {4'd3,4'd2,4'd0,4'd1}, packed; region i at `[i*WAIT_W +: WAIT_W]`.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `cpu_address`  in  ADDR_W  CPU address.
- `cpu_valid`  in  1  address valid this cycle.
- `select`  out  N_REGIONS  one-hot region select.
- `cpu_rdy`  out  1  CPU ready; low stalls the CPU.
- `unmapped`  out  1  sticky flag: an unmapped access occurred.
- `unmapped_address`  out  ADDR_W  address of the first unmapped access.
- `clr_unmapped`  in  1  clears `unmapped` (one-cycle pulse).

## Operation
- **Match rule:** region i matches when `(cpu_address & MASK_i) == BASE_i`. The lowest matching index wins. `select` is never multi-hot.
- **FSM states:** IDLE and WAIT. Also holds a `WAIT_W`-bit counter `cnt` and a latched region index `reg_q`.
- **IDLE, `cpu_valid`=0:**
  - `select`=0, `cpu_rdy`=1.
- **IDLE, `cpu_valid`=1, match region i, W_i=0:**
  - `select`=onehot(i) combinationally, `cpu_rdy`=1.
  - Stay in IDLE; this is a single-cycle access.
- **IDLE, `cpu_valid`=1, match region i, W_i>0:**
  - `select`=onehot(i), `cpu_rdy`=0.
  - Next state WAIT, `cnt`<=W_i-1, `reg_q`<=i.
- **WAIT:**
  - `select`=onehot(`reg_q`). The address is ignored, because the CPU holds it while stalled.
  - If `cnt`!=0: `cpu_rdy`=0, `cnt`<=`cnt`-1.
  - If `cnt`==0: `cpu_rdy`=1, next state IDLE.
- **IDLE, `cpu_valid`=1, no match:**
  - `select`=0, `cpu_rdy`=1 (never stall on unmapped).
  - If `unmapped`=0: set `unmapped`, latch `unmapped_address`<=`cpu_address`.
  - If already set: keep the first address.
- **`clr_unmapped`:** clears `unmapped` next edge; `unmapped_address` is retained. If it coincides with a new unmapped access, set wins and the new address is captured.
- **Reset, while `rst`=1:** `select`=0, `cpu_rdy`=1, state IDLE, `cnt`=0, `reg_q`=0, `unmapped`=0, `unmapped_address`=0.
- **Reset mid-WAIT:** abort immediately (asynchronous); `cpu_rdy` returns high in the same cycle.

## Timing
- `select` and `cpu_rdy` for the first cycle of an access are combinational from `cpu_address`/`cpu_valid` (zero-latency decode). All later cycles come from registered state.
- An access to a region with W wait states occupies exactly W+1 cycles, with `cpu_rdy` low for the first W cycles and high on the last.
- Back-to-back: the cycle after the completing (rdy-high) WAIT cycle is IDLE and decodes a new address with no bubble.
- `unmapped` and `unmapped_address` update on the clock edge after the offending cycle.
- W_i=`2^WAIT_W-1` (15) is legal: 15 low cycles, no counter wrap.

## Test plan
- **Reset:** assert `rst` mid-WAIT on a 0x8000 access -> `cpu_rdy`=1, `select`=0 in the same cycle. After release, all outputs are at their reset values.
- **RAM and ROM timing:**
  - 0x0000 and 0x3FFF -> `select`=4'b0010, `cpu_rdy`=1, 1 cycle each.
  - 0xFFFA -> `select`=4'b1000, `cpu_rdy` low 3 cycles then high; `select` holds for all 4 cycles even if the address is changed during WAIT.
- **Priority:**
  - 0x7000..0x7003 -> region 0 (4'b0001) with 1 wait, not VRAM.
  - 0x4000 and 0x5FFF -> 4'b0100, 2 waits.
- **Unmapped:**
  - 0x6000 -> `select`=0, no stall, `unmapped`=1, `unmapped_address`=0x6000.
  - A following 0x7004 keeps 0x6000.
  - `clr_unmapped` coinciding with a 0x7FFF access -> `unmapped`=1, address 0x7FFF.
- **Back-to-back:** 0x4000 (2 waits) then 0x0000 immediately -> rdy pattern 0,0,1,1 with `select` 0100,0100,0100,0010.
- **Parameter sweep:** N_REGIONS=2, WAIT_W=2, W={3,0} -> region 0 gives 3 low cycles; all-`cpu_valid`=0 traffic gives `select`=0, `cpu_rdy`=1.
